// File: rtl/mult_booth.sv
// Radix-2 Booth signed 32x32 multiplier: one add/subtract-and-shift step per clock,
// 32 steps per product, with a one-cycle completion pulse and overflow flag.

module cla32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;
    logic [8:0]  c_grp;

    assign g        = a & b;
    assign p        = a ^ b;
    assign c_grp[0] = cin;

    // 4-bit lookahead groups; group carries ripple between groups
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_grp
            logic [3:0] gg;
            logic [3:0] pp;
            logic       ci;
            assign gg = g[4*gi +: 4];
            assign pp = p[4*gi +: 4];
            assign ci = c_grp[gi];
            assign c[4*gi]     = ci;
            assign c[4*gi + 1] = gg[0] | (pp[0] & ci);
            assign c[4*gi + 2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & ci);
            assign c[4*gi + 3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                               | (pp[2] & pp[1] & pp[0] & ci);
            assign c_grp[gi + 1] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                                 | (pp[3] & pp[2] & pp[1] & gg[0])
                                 | (pp[3] & pp[2] & pp[1] & pp[0] & ci);
        end
    endgenerate

    assign sum  = p ^ c;
    assign cout = c_grp[8];
endmodule

module mult_booth (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_reg, state_next;
    logic [65:0] p_reg, p_next;      // {acc[32:0], q[31:0], q_1}
    logic [31:0] m_reg, m_next;
    logic [5:0]  cnt_reg, cnt_next;
    logic [31:0] result_reg, result_next;
    logic        exc_reg, exc_next;
    logic        rdy_reg, rdy_next;

    logic [32:0] acc;
    logic        do_add;
    logic        do_sub;
    logic [31:0] add_b;
    logic [31:0] add_sum;
    logic        add_cout;
    logic [32:0] sel_acc;
    logic [65:0] step_p;
    logic [32:0] prod_hi;

    assign acc    = p_reg[65:33];
    assign do_add = (p_reg[1:0] == 2'b01);
    assign do_sub = (p_reg[1:0] == 2'b10);
    assign add_b  = do_sub ? ~m_reg : m_reg;

    cla32 u_cla (
        .a    (acc[31:0]),
        .b    (add_b),
        .cin  (do_sub),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Bit 32 completes a 33-bit add using the sign-extended operands
    always_comb begin
        sel_acc = acc;
        if (do_add || do_sub)
            sel_acc = {acc[32] ^ add_b[31] ^ add_cout, add_sum};
    end

    assign step_p  = {sel_acc[32], sel_acc, p_reg[32:1]};
    assign prod_hi = step_p[64:32];

    always_comb begin
        state_next  = state_reg;
        p_next      = p_reg;
        m_next      = m_reg;
        cnt_next    = cnt_reg;
        result_next = result_reg;
        exc_next    = exc_reg;
        rdy_next    = 1'b0;
        if (ctrl_MULT) begin
            m_next     = data_operandA;
            p_next     = {33'd0, data_operandB, 1'b0};
            cnt_next   = 6'd0;
            state_next = BUSY;
        end else begin
            case (state_reg)
                BUSY: begin
                    p_next   = step_p;
                    cnt_next = cnt_reg + 6'd1;
                    if (cnt_reg == 6'd31) begin
                        result_next = step_p[32:1];
                        exc_next    = ~((&prod_hi) | ~(|prod_hi));
                        rdy_next    = 1'b1;
                        state_next  = DONE;
                    end
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg  <= IDLE;
            p_reg      <= 66'd0;
            m_reg      <= 32'd0;
            cnt_reg    <= 6'd0;
            result_reg <= 32'd0;
            exc_reg    <= 1'b0;
            rdy_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            p_reg      <= p_next;
            m_reg      <= m_next;
            cnt_reg    <= cnt_next;
            result_reg <= result_next;
            exc_reg    <= exc_next;
            rdy_reg    <= rdy_next;
        end
    end

    assign data_result    = result_reg;
    assign data_exception = exc_reg;
    assign data_resultRDY = rdy_reg;
endmodule

// File: tb/tb_mult_booth.sv
// Self-checking bench for mult_booth: directed vector table, randomized products
// against an arithmetic reference, and reset/abort/held-start sequences.

module tb_mult_booth;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ctrl_MULT = 1'b0;
    logic [31:0] data_operandA = 32'd0;
    logic [31:0] data_operandB = 32'd0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int checks = 0;
    int errors = 0;

    mult_booth dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Reference: full 64-bit signed product; overflow when it differs from the
    // sign extension of its own low word
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic e);
        longint prod;
        longint low_ext;
        prod    = longint'(signed'(a)) * longint'(signed'(b));
        r       = prod[31:0];
        low_ext = longint'(signed'(r));
        e       = (prod != low_ext);
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        ctrl_MULT     = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
    endtask

    // One multiply: checks latency, hold of old outputs, result, exception, pulse width
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic ee, input string tag);
        logic [31:0] prev_res;
        logic        prev_exc;
        logic        held;
        int          lat;
        prev_res = data_result;
        prev_exc = data_exception;
        held     = 1'b1;
        lat      = -1;
        start(a, b);
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            data_operandA = $urandom;
            data_operandB = $urandom;
            @(posedge clock);
            #1;
            if (data_resultRDY) lat = k;
            else if (data_result !== prev_res || data_exception !== prev_exc) held = 1'b0;
        end
        $display("op %s: A=0x%08h B=0x%08h -> result=0x%08h exc=%0d latency=%0d",
                 tag, a, b, data_result, data_exception, lat);
        chk({tag, " latency"}, lat, 32);
        chk({tag, " hold"}, {31'd0, held}, 32'd1);
        chk({tag, " result"}, data_result, er);
        chk({tag, " exception"}, {31'd0, data_exception}, {31'd0, ee});
        @(posedge clock);
        #1;
        chk({tag, " rdy_pulse_end"}, {31'd0, data_resultRDY}, 32'd0);
    endtask

    initial begin
        logic [31:0] ra, rb, rr;
        logic        re;
        int          pulses;
        int          pulse_at;

        vecs[0] = '{32'd3,          32'd5,          32'h0000000F, 1'b0};
        vecs[1] = '{32'hFFFFFFF9,   32'd6,          32'hFFFFFFD6, 1'b0};
        vecs[2] = '{32'h7FFFFFFF,   32'd1,          32'h7FFFFFFF, 1'b0};
        vecs[3] = '{32'h80000000,   32'hFFFFFFFF,   32'h80000000, 1'b1};
        vecs[4] = '{32'h00010000,   32'h00010000,   32'h00000000, 1'b1};
        vecs[5] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000001, 1'b0};
        vecs[6] = '{32'h80000000,   32'h80000000,   32'h00000000, 1'b1};
        vecs[7] = '{32'h80000000,   32'd1,          32'h80000000, 1'b0};

        // Reset with start asserted: reset must win
        ctrl_MULT = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("reset result", data_result, 32'd0);
        chk("reset exception", {31'd0, data_exception}, 32'd0);
        chk("reset rdy", {31'd0, data_resultRDY}, 32'd0);
        ctrl_MULT = 1'b0;
        reset     = 1'b1;
        @(posedge clock);
        #1;
        chk("idle rdy", {31'd0, data_resultRDY}, 32'd0);

        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].exc, $sformatf("vec%0d", i));

        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 3 == 0) begin
                ra = 32'($signed(ra) >>> 17);
                rb = 32'($signed(rb) >>> 17);
            end
            model(ra, rb, rr, re);
            run_op(ra, rb, rr, re, $sformatf("rnd%0d", i));
        end

        // Reset at step 10 discards the operation
        start(32'd3, 32'd5);
        repeat (9) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        chk("midreset result", data_result, 32'd0);
        chk("midreset exception", {31'd0, data_exception}, 32'd0);
        chk("midreset rdy", {31'd0, data_resultRDY}, 32'd0);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) pulses++;
        end
        $display("seq midreset: rdy pulses=%0d result=0x%08h", pulses, data_result);
        chk("midreset no_rdy", pulses, 0);

        // Restart at step 20 aborts the first product
        start(32'd3, 32'd5);
        repeat (19) @(posedge clock);
        #1;
        start(32'd4, 32'd4);
        pulses   = 0;
        pulse_at = -1;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                pulses++;
                if (pulse_at < 0) begin
                    pulse_at = k;
                    chk("abort result", data_result, 32'h00000010);
                end
            end
        end
        $display("seq abort: rdy pulses=%0d at=%0d result=0x%08h", pulses, pulse_at, data_result);
        chk("abort pulses", pulses, 1);
        chk("abort latency", pulse_at, 32);

        // Start held high restarts every edge
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd9;
        pulses        = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) pulses++;
        end
        ctrl_MULT = 1'b0;
        $display("seq held_start: rdy pulses=%0d", pulses);
        chk("held_start no_rdy", pulses, 0);
        chk("held_start result_kept", data_result, 32'h00000010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_booth.md
MULT_BOOTH -- requirements
Module: mult_booth

Interface
REQ-001 Port list, clock and reset first:
- clock  input  1  sole clock; all state updates on its rising edge
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock
- ctrl_MULT  input  1  start strobe; sampled each rising edge
- data_operandA  input  32  signed multiplicand; sampled only on an edge where start is accepted
- data_operandB  input  32  signed multiplier; sampled only on an edge where start is accepted
- data_result  output  32  low 32 bits of the signed product; registered
- data_exception  output  1  high if the product does not fit in signed 32 bits; registered
- data_resultRDY  output  1  one-cycle completion pulse; registered
REQ-002 The block SHALL have no parameters; all widths are fixed at 32.

Function
REQ-003 The block SHALL implement a radix-2 Booth signed multiplier with exactly one add/subtract-and-shift step per clock.
REQ-004 Each add/subtract SHALL be performed by the ALU's 32-bit carry-lookahead adder; subtraction SHALL use inverted operand and Cin=1.
REQ-005 Datapath registers SHALL be:
- M: 32-bit held multiplicand
- P: 66 bits = {ACC[32:0] (sign-extended high), Q[31:0], q_1}
- cnt: 6-bit step counter
REQ-006 ACC SHALL be 33 bits so that ACC ± M never overflows, including M = 0x80000000; bit 32 SHALL be formed by sign extension around the 32-bit adder.
REQ-007 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-008 Start acceptance: on any edge with reset=1 and ctrl_MULT=1, in any state:
- M <= data_operandA
- ACC <= 0
- Q <= data_operandB
- q_1 <= 0
- cnt <= 0
- state <= BUSY
REQ-009 A start accepted in BUSY or DONE SHALL abort the current operation without producing data_resultRDY for it.
REQ-010 In BUSY with ctrl_MULT=0, each edge SHALL:
- select by {Q[0], q_1}: 01 -> ACC+M, 10 -> ACC-M, 00/11 -> ACC
- arithmetic-shift the whole of P right by 1
- increment cnt
REQ-011 On the BUSY edge that completes step 32 (cnt=31 before the edge), the block SHALL:
- load data_result with the low 32 bits of the product
- load data_exception
- set data_resultRDY=1
- go to DONE
REQ-012 data_exception SHALL be 1 exactly when product bits [63:31] are not all equal.
REQ-013 In DONE with ctrl_MULT=0, the next edge SHALL clear data_resultRDY and go to IDLE.
REQ-014 Latency: start accepted at edge E0 -> data_resultRDY high from E32 to E33, exactly one cycle.
REQ-015 data_result and data_exception SHALL hold their values from REQ-011 until the next completion or reset.
REQ-016 A start accepted at edge E0 SHALL NOT change data_result or data_exception before that operation completes.
REQ-017 data_resultRDY SHALL be 0 in IDLE and BUSY.
REQ-018 ctrl_MULT held high continuously SHALL restart the operation on every edge, so data_resultRDY never asserts.
REQ-019 Operand changes while not accepting a start SHALL have no effect.

Reset
REQ-020 On any edge with reset=0, regardless of ctrl_MULT or state:
- state <= IDLE
- data_result <= 0
- data_exception <= 0
- data_resultRDY <= 0
- P, M, cnt <= 0
REQ-021 reset=0 SHALL take priority over ctrl_MULT on the same edge.
REQ-022 Reset during BUSY SHALL discard the operation; no data_resultRDY SHALL follow.

Verification
REQ-023 A=3, B=5, 1-cycle start -> data_resultRDY high exactly in the cycle after the 32nd subsequent edge; result 0x0000000F, exception 0.
REQ-024 A=-7, B=6 -> result 0xFFFFFFD6, exception 0; A=0x7FFFFFFF, B=1 -> 0x7FFFFFFF, exception 0.
REQ-025 A=0x80000000, B=0xFFFFFFFF -> result 0x80000000, exception 1.
REQ-026 A=0x00010000, B=0x00010000 -> result 0x00000000, exception 1.
REQ-027 Start 3×5, assert reset=0 for one edge at step 10 -> all outputs 0 and no data_resultRDY for 40 cycles.
REQ-028 Start 3×5, then start 4×4 at step 20 -> exactly one data_resultRDY, 32 edges after the second start, result 0x00000010.
